imem_loadable_fetch: RTL and testbench

Parametrised, loadable instruction memory for the pipeline's IF stage. It replaces a hard-coded reset-time program with a word-write load port, and adds a valid/ready fetch request/response pair with one-cycle registered read latency, back-pressure, and fault reporting for misaligned and out-of-range PCs. It sits between the PC register and the IF/ID pipeline register.

---
 rtl/imem_loadable_fetch.sv | 137 +++++++++++++
 tb/tb_imem_loadable_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable_fetch.sv
// Loadable instruction memory for the IF stage: word-write load port, then a
// valid/ready fetch port with one-cycle registered read and PC fault reporting.
module imem_loadable_fetch #(
   parameter int unsigned DEPTH_BYTES = 128,
   parameter int unsigned ADDR_W      = 32,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
   parameter int unsigned WCNT_W      = $clog2(DEPTH_BYTES/4) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic              ld_done,
   output logic              ld_err,
   output logic [WCNT_W-1:0] ld_words,
   input  logic              f_req_valid,
   output logic              f_req_ready,
   input  logic [ADDR_W-1:0] f_pc,
   output logic              f_rsp_valid,
   input  logic              f_rsp_ready,
   output logic [31:0]       f_rsp_instr,
   output logic [1:0]        f_rsp_fault
);

   localparam int unsigned NWORDS = DEPTH_BYTES / 4;
   localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);

   typedef enum logic {
      ST_LOAD,
      ST_RUN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]       r_mem [NWORDS];
   logic [WCNT_W-1:0] r_ld_words;
   logic              r_ld_err;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_instr;
   logic [1:0]        r_rsp_fault;

   logic              w_ld_ready;
   logic              w_ld_done;
   logic [ADDR_W-1:0] w_ld_base;
   logic              w_ld_inrange;
   logic              w_ld_fire;
   logic              w_ld_wr;
   logic [IDX_W-1:0]  w_ld_idx;
   logic              w_f_req_ready;
   logic              w_f_fire;
   logic              w_f_misal;
   logic              w_f_oor;
   logic [1:0]        w_f_fault;
   logic [IDX_W-1:0]  w_f_idx;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_LOAD;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_ready  = 1'b0;
      w_ld_done   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_ld_ready = 1'b1;
            if (ld_valid && ld_last) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_ld_done = 1'b1;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // ---------------------------------------------------------------- load port
   // Aligned base compared directly against the last word address so a base
   // near the top of the address space cannot wrap into range.
   assign w_ld_base    = ld_addr & ~ADDR_W'(3);
   assign w_ld_inrange = (w_ld_base <= LAST_WORD_ADDR);
   assign w_ld_fire    = ld_valid && w_ld_ready && !reset;
   assign w_ld_wr      = w_ld_fire && w_ld_inrange;
   assign w_ld_idx     = w_ld_base[IDX_W+1:2];

   always_ff @(posedge clk) begin
      if (w_ld_wr) r_mem[w_ld_idx] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ld_words <= '0;
         r_ld_err   <= 1'b0;
      end else begin
         if (w_ld_wr && (r_ld_words != '1)) r_ld_words <= r_ld_words + 1'b1;
         if (w_ld_fire && !w_ld_inrange)    r_ld_err   <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- fetch port
   assign w_f_req_ready = (r_state == ST_RUN) && (!r_rsp_valid || f_rsp_ready);
   assign w_f_fire      = f_req_valid && w_f_req_ready;
   assign w_f_misal     = |f_pc[1:0];
   assign w_f_oor       = (f_pc > LAST_WORD_ADDR);
   assign w_f_fault     = w_f_misal ? 2'b01 : (w_f_oor ? 2'b10 : 2'b00);
   assign w_f_idx       = f_pc[IDX_W+1:2];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_instr <= NOP_INSTR;
         r_rsp_fault <= 2'b00;
      end else if (w_f_fire) begin
         r_rsp_valid <= 1'b1;
         r_rsp_fault <= w_f_fault;
         r_rsp_instr <= (w_f_fault != 2'b00) ? NOP_INSTR : r_mem[w_f_idx];
      end else if (f_rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign ld_ready    = w_ld_ready;
   assign ld_done     = w_ld_done;
   assign ld_err      = r_ld_err;
   assign ld_words    = r_ld_words;
   assign f_req_ready = w_f_req_ready;
   assign f_rsp_valid = r_rsp_valid;
   assign f_rsp_instr = r_rsp_instr;
   assign f_rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_imem_loadable_fetch.sv
// Directed + randomized bench for imem_loadable_fetch against a byte-level
// reference model of the load/fetch rules.
module tb_imem_loadable_fetch;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned AW    = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int unsigned WCW   = $clog2(DEPTH/4) + 1;
   localparam int unsigned WMAX  = (1 << WCW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [AW-1:0] ld_addr = '0;
   logic [31:0]   ld_data = '0;
   logic          ld_last = 1'b0;
   logic          ld_done;
   logic          ld_err;
   logic [WCW-1:0] ld_words;
   logic          f_req_valid = 1'b0;
   logic          f_req_ready;
   logic [AW-1:0] f_pc = '0;
   logic          f_rsp_valid;
   logic          f_rsp_ready = 1'b0;
   logic [31:0]   f_rsp_instr;
   logic [1:0]    f_rsp_fault;

   imem_loadable_fetch #(
      .DEPTH_BYTES (DEPTH),
      .ADDR_W      (AW),
      .NOP_INSTR   (NOP),
      .WCNT_W      (WCW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_done     (ld_done),
      .ld_err      (ld_err),
      .ld_words    (ld_words),
      .f_req_valid (f_req_valid),
      .f_req_ready (f_req_ready),
      .f_pc        (f_pc),
      .f_rsp_valid (f_rsp_valid),
      .f_rsp_ready (f_rsp_ready),
      .f_rsp_instr (f_rsp_instr),
      .f_rsp_fault (f_rsp_fault)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // reference model
   byte unsigned m_mem [DEPTH];
   logic          m_run   = 1'b0;
   int unsigned   m_words = 0;
   logic          m_err   = 1'b0;
   logic          m_rv    = 1'b0;
   logic [31:0]   m_instr = NOP;
   logic [1:0]    m_fault = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_fetch(input logic [31:0] pc, output logic [31:0] ins, output logic [1:0] flt);
      longint unsigned p;
      p = pc;
      if (pc[1:0] != 2'b00) begin
         ins = NOP; flt = 2'b01;
      end else if (p > DEPTH - 4) begin
         ins = NOP; flt = 2'b10;
      end else begin
         ins = {m_mem[p+3], m_mem[p+2], m_mem[p+1], m_mem[p]};
         flt = 2'b00;
      end
   endtask

   task automatic check_state();
      check("ld_done", 32'(ld_done), 32'(m_run));
      check("ld_err", 32'(ld_err), 32'(m_err));
      check("ld_words", 32'(ld_words), m_words);
      check("rsp_valid", 32'(f_rsp_valid), 32'(m_rv));
      if (m_rv) begin
         check("rsp_instr", f_rsp_instr, m_instr);
         check("rsp_fault", 32'(f_rsp_fault), 32'(m_fault));
      end
   endtask

   task automatic tick(input logic lv, input logic [31:0] la, input logic [31:0] ldat, input logic ll,
                       input logic rv, input logic [31:0] pc, input logic rr);
      logic            f_acc;
      longint unsigned base;
      logic [31:0]     ei;
      logic [1:0]      ef;
      ld_valid = lv; ld_addr = la; ld_data = ldat; ld_last = ll;
      f_req_valid = rv; f_pc = pc; f_rsp_ready = rr;
      #1;
      f_acc = m_run && (!m_rv || rr);
      check("ld_ready", 32'(ld_ready), 32'(!m_run));
      check("f_req_ready", 32'(f_req_ready), 32'(f_acc));
      f_acc = f_acc && rv;
      @(posedge clk);
      #1;
      if (!m_run && lv) begin
         base = la & 32'hFFFF_FFFC;
         if (base + 3 <= DEPTH - 1) begin
            for (int b = 0; b < 4; b++) m_mem[base + longint'(b)] = ldat[8*b +: 8];
            if (m_words < WMAX) m_words++;
         end else begin
            m_err = 1'b1;
         end
         if (ll) m_run = 1'b1;
      end
      if (f_acc) begin
         exp_fetch(pc, ei, ef);
         m_rv = 1'b1; m_instr = ei; m_fault = ef;
      end else if (rr) begin
         m_rv = 1'b0;
      end
      check_state();
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] d, input logic last);
      tick(1'b1, a, d, last, 1'b0, '0, 1'b1);
   endtask

   task automatic fe(input logic [31:0] pc, input logic rr);
      tick(1'b0, '0, '0, 1'b0, 1'b1, pc, rr);
   endtask

   task automatic idle();
      tick(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic do_reset(input logic lv, input logic [31:0] la, input logic [31:0] ldat);
      reset = 1'b1;
      ld_valid = lv; ld_addr = la; ld_data = ldat; ld_last = 1'b0;
      f_req_valid = 1'b0; f_rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_run = 1'b0; m_words = 0; m_err = 1'b0;
      m_rv = 1'b0; m_instr = NOP; m_fault = 2'b00;
      ld_valid = 1'b0;
      #1;
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_f_req_ready", 32'(f_req_ready), 32'd0);
      check("rst_instr", f_rsp_instr, NOP);
      check("rst_fault", 32'(f_rsp_fault), 32'd0);
      check_state();
   endtask

   function automatic logic [31:0] rand_pc();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 5)      return 32'(4 * $urandom_range(0, DEPTH/4 - 1));
      else if (r <= 7) return 32'(4 * $urandom_range(0, DEPTH/4 + 1) + $urandom_range(1, 3));
      else if (r == 8) return 32'(DEPTH + 4 * $urandom_range(0, 100));
      else             return 32'hFFFF_FFFC;
   endfunction

   initial begin
      // ---- phase A: initial load and basic fetches
      do_reset(1'b0, '0, '0);
      for (int i = 0; i < 10; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, 32'(4*i), 1'b1);
      ld(32'd0,  32'h00C28283, 1'b0);
      ld(32'd4,  32'h800100B3, 1'b0);
      ld(32'd8,  32'h00209133, 1'b0);
      ld(32'd12, 32'h00C54AB3, 1'b1);
      check("ld_done_after_last", 32'(ld_done), 32'd1);
      fe(32'd0, 1'b1);
      check("pc0_instr", f_rsp_instr, 32'h00C28283);
      fe(32'd4, 1'b1);
      fe(32'd8, 1'b1);
      fe(32'd12, 1'b1);
      check("pc12_instr", f_rsp_instr, 32'h00C54AB3);
      idle();
      check("words_after_4", 32'(ld_words), 32'd4);

      fe(32'd6, 1'b1);
      check("pc6_instr", f_rsp_instr, NOP);
      check("pc6_fault", 32'(f_rsp_fault), 32'd1);
      fe(32'(DEPTH - 2), 1'b1);
      check("pcD-2_fault", 32'(f_rsp_fault), 32'd1);
      fe(32'(DEPTH), 1'b1);
      check("pcD_fault", 32'(f_rsp_fault), 32'd2);
      fe(32'hFFFF_FFFC, 1'b1);
      idle();

      // back-pressure during a pc=0,4 stream
      fe(32'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         fe(32'd4, 1'b0);
         check("stall_instr", f_rsp_instr, 32'h00C28283);
      end
      fe(32'd4, 1'b1);
      check("release_instr", f_rsp_instr, 32'h800100B3);
      idle();

      // ---- phase B: reset with pending response, then full reload
      fe(32'd8, 1'b0);
      do_reset(1'b1, 32'd0, 32'hDEADBEEF);
      for (int w = 0; w < DEPTH/4; w++)
         tick(1'b1, 32'(4*w), $urandom, 1'b0, 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)));
      ld(32'(DEPTH), 32'h5555_AAAA, 1'b0);
      check("oor_load_err", 32'(ld_err), 32'd1);
      ld(32'h11, 32'hA1B2C3D4, 1'b0);
      for (int i = 0; i < 40; i++)
         ld(32'(4 * $urandom_range(5, DEPTH/4 - 1) + $urandom_range(0, 3)), $urandom, 1'b0);
      for (int i = 0; i < 10; i++)
         ld((i == 0) ? 32'hFFFF_FFFC : 32'(DEPTH + $urandom_range(0, 1000)), $urandom, 1'b0);
      check("words_saturated", 32'(ld_words), WMAX);
      ld(32'd0, 32'h0BAD_F00D, 1'b1);
      idle();
      fe(32'd0, 1'b1);
      check("reload_pc0", f_rsp_instr, 32'h0BAD_F00D);
      fe(32'd16, 1'b1);
      check("addr11_word", f_rsp_instr, 32'hA1B2C3D4);
      fe(32'(DEPTH - 4), 1'b1);
      check("pcD-4_fault", 32'(f_rsp_fault), 32'd0);

      // ---- randomized run traffic (load port must be ignored)
      for (int i = 0; i < 300; i++)
         tick(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 3) != 0));
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
